// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART command controller: command opcodes,
// fixed operand addresses and the frame-parser state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OP_A_ADDR = 0;
  localparam int OP_B_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN
  } state_t;

  // Maps a command byte to the first state of its frame; unknown bytes map
  // back to ST_IDLE, which the caller reports as a framing error.
  function automatic state_t decode_cmd(input logic [7:0] b);
    case (b)
      CMD_WR:      return ST_WR_ADDR;
      CMD_RD:      return ST_RD_ADDR;
      CMD_ALU_OP:  return ST_OP_A;
      CMD_ALU_NOP: return ST_ALU_FUN;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// expire in the cycle the count reaches TIMEOUT_CYC-1.
module frame_timeout #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  // Combinational so the parser can react on the very edge the limit is hit.
  assign expire = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST || clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Parses UART command frames (write / read / ALU with or without operands)
// into one-cycle register-file and ALU strobes, flagging framing errors.
module rx_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  FRAME_ERR
);

  state_t                state;
  state_t                cmd_state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic                  tmo_clr;
  logic                  tmo_en;
  logic                  tmo_expire;

  assign cmd_state = decode_cmd(8'(RX_P_DATA));
  assign rx_addr   = RX_P_DATA[ADDR_WIDTH-1:0];

  // An accepted byte clears the watchdog, so a byte landing on the expiry
  // cycle wins and no error is raised.
  assign tmo_clr = (state == ST_IDLE) || RX_D_VLD;
  assign tmo_en  = !tmo_clr;

  frame_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      wr_addr    <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      FRAME_ERR  <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each is a single-cycle pulse;
      // the data outputs have no default and therefore hold their last value.
      RF_WrEn   <= 1'b0;
      RF_RdEn   <= 1'b0;
      ALU_EN    <= 1'b0;
      FRAME_ERR <= 1'b0;

      if (RX_D_VLD) begin
        case (state)
          ST_IDLE: begin
            state <= cmd_state;
            if (cmd_state == ST_IDLE) begin
              FRAME_ERR <= 1'b1;
            end
          end
          ST_WR_ADDR: begin
            wr_addr <= rx_addr;
            state   <= ST_WR_DATA;
          end
          ST_WR_DATA: begin
            RF_WrEn    <= 1'b1;
            RF_Address <= wr_addr;
            RF_WrData  <= RX_P_DATA;
            state      <= ST_IDLE;
          end
          ST_RD_ADDR: begin
            RF_RdEn    <= 1'b1;
            RF_Address <= rx_addr;
            state      <= ST_IDLE;
          end
          ST_OP_A: begin
            RF_WrEn    <= 1'b1;
            RF_Address <= ADDR_WIDTH'(OP_A_ADDR);
            RF_WrData  <= RX_P_DATA;
            state      <= ST_OP_B;
          end
          ST_OP_B: begin
            RF_WrEn    <= 1'b1;
            RF_Address <= ADDR_WIDTH'(OP_B_ADDR);
            RF_WrData  <= RX_P_DATA;
            state      <= ST_ALU_FUN;
          end
          ST_ALU_FUN: begin
            ALU_EN  <= 1'b1;
            ALU_FUN <= RX_P_DATA[3:0];
            state   <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end else if (tmo_expire) begin
        state     <= ST_IDLE;
        FRAME_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed bench for rx_cmd_ctrl: a byte-queue frame model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_rx_cmd_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int TMO = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic          RF_WrEn;
  logic          RF_RdEn;
  logic [AW-1:0] RF_Address;
  logic [DW-1:0] RF_WrData;
  logic          ALU_EN;
  logic [3:0]    ALU_FUN;
  logic          FRAME_ERR;

  rx_cmd_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RF_WrEn    (RF_WrEn),
    .RF_RdEn    (RF_RdEn),
    .RF_Address (RF_Address),
    .RF_WrData  (RF_WrData),
    .ALU_EN     (ALU_EN),
    .ALU_FUN    (ALU_FUN),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: collect bytes of the current frame in a queue and decide on
  // completion from the command byte and the queue length.
  logic [7:0]    frame[$];
  int            gap = 0;
  logic          e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  logic [3:0]    e_fun  = '0;

  task automatic model_byte(input logic [7:0] b);
    if (frame.size() == 0) begin
      if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) frame.push_back(b);
      else e_err = 1'b1;
    end else begin
      frame.push_back(b);
      case (frame[0])
        8'hAA: if (frame.size() == 3) begin
          e_wr = 1'b1; e_addr = frame[1][AW-1:0]; e_data = b; frame.delete();
        end
        8'hBB: begin
          e_rd = 1'b1; e_addr = b[AW-1:0]; frame.delete();
        end
        8'hCC: begin
          if (frame.size() == 2) begin e_wr = 1'b1; e_addr = 0; e_data = b; end
          else if (frame.size() == 3) begin e_wr = 1'b1; e_addr = 1; e_data = b; end
          else begin e_alu = 1'b1; e_fun = b[3:0]; frame.delete(); end
        end
        default: begin
          e_alu = 1'b1; e_fun = b[3:0]; frame.delete();
        end
      endcase
    end
  endtask

  always @(posedge CLK) begin
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (RST) begin
      frame.delete();
      gap = 0;
      e_addr = '0; e_data = '0; e_fun = '0;
    end else if (RX_D_VLD) begin
      gap = 0;
      model_byte(RX_P_DATA);
    end else if (frame.size() != 0) begin
      gap++;
      if (gap >= TMO) begin
        frame.delete();
        gap = 0;
        e_err = 1'b1;
      end
    end
  end

  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0;

  always @(negedge CLK) begin
    if (check_en) begin
      check("cyc_wren",  32'(RF_WrEn),    32'(e_wr));
      check("cyc_rden",  32'(RF_RdEn),    32'(e_rd));
      check("cyc_alu",   32'(ALU_EN),     32'(e_alu));
      check("cyc_err",   32'(FRAME_ERR),  32'(e_err));
      check("cyc_addr",  32'(RF_Address), 32'(e_addr));
      check("cyc_data",  32'(RF_WrData),  32'(e_data));
      check("cyc_fun",   32'(ALU_FUN),    32'(e_fun));
      wr_cnt  += int'(RF_WrEn);
      rd_cnt  += int'(RF_RdEn);
      alu_cnt += int'(ALU_EN);
      err_cnt += int'(FRAME_ERR);
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte was
  // accepted, when the resulting registered outputs are visible.
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = '0;
    repeat (2) @(negedge CLK);
    check_en = 1'b1;
    check("rst_addr", 32'(RF_Address), 0);
    check("rst_data", 32'(RF_WrData),  0);
    check("rst_err",  32'(FRAME_ERR),  0);
    RST = 1'b0;
    @(negedge CLK);

    // Write frame, then a read frame back-to-back with no gap.
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    check("wr_en",   32'(RF_WrEn),    1);
    check("wr_addr", 32'(RF_Address), 5);
    check("wr_data", 32'(RF_WrData),  32'h3C);
    send_byte(8'hBB); send_byte(8'h17);
    check("rd_en",   32'(RF_RdEn),    1);
    check("rd_addr", 32'(RF_Address), 7);
    check("rd_nowr", 32'(RF_WrEn),    0);
    @(negedge CLK);
    check("rd_pulse_end", 32'(RF_RdEn),    0);
    check("rd_addr_hold", 32'(RF_Address), 7);

    // ALU with operands.
    send_byte(8'hCC); send_byte(8'h10);
    check("opa_addr", 32'(RF_Address), 0);
    check("opa_data", 32'(RF_WrData),  32'h10);
    send_byte(8'h20);
    check("opb_addr", 32'(RF_Address), 1);
    check("opb_data", 32'(RF_WrData),  32'h20);
    send_byte(8'h02);
    check("alu_en",  32'(ALU_EN),  1);
    check("alu_fun", 32'(ALU_FUN), 2);

    // Unknown command, then ALU without operands.
    send_byte(8'h55);
    check("unk_err", 32'(FRAME_ERR), 1);
    check("unk_nowr", 32'(RF_WrEn), 0);
    send_byte(8'hDD); send_byte(8'h01);
    check("nop_alu", 32'(ALU_EN),  1);
    check("nop_fun", 32'(ALU_FUN), 1);
    repeat (3) @(negedge CLK);

    // Data byte on the last permitted cycle is accepted.
    send_byte(8'hAA); send_byte(8'h03);
    repeat (TMO - 1) @(negedge CLK);
    send_byte(8'h66);
    check("edge_wr",   32'(RF_WrEn),    1);
    check("edge_addr", 32'(RF_Address), 3);
    check("edge_data", 32'(RF_WrData),  32'h66);
    check("edge_err",  32'(FRAME_ERR),  0);

    // Silence expires the frame.
    send_byte(8'hAA); send_byte(8'h03);
    waited = 0;
    while (FRAME_ERR !== 1'b1 && waited < TMO + 8) begin
      @(negedge CLK);
      waited++;
    end
    check("tmo_cycles", 32'(waited), 32'(TMO));
    send_byte(8'h99);
    check("late_err",  32'(FRAME_ERR), 1);
    check("late_nowr", 32'(RF_WrEn),   0);

    // Reset between operand A and operand B abandons the frame.
    send_byte(8'hCC); send_byte(8'h44);
    check("pre_rst_data", 32'(RF_WrData), 32'h44);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mid_rst_wr",   32'(RF_WrEn),    0);
    check("mid_rst_addr", 32'(RF_Address), 0);
    check("mid_rst_data", 32'(RF_WrData),  0);
    check("mid_rst_fun",  32'(ALU_FUN),    0);
    send_byte(8'h20);
    check("post_rst_err", 32'(FRAME_ERR), 1);
    send_byte(8'h02);
    check("post_rst_noalu", 32'(ALU_EN), 0);
    repeat (3) @(negedge CLK);

    check("n_writes", 32'(wr_cnt),  5);
    check("n_reads",  32'(rd_cnt),  1);
    check("n_alu",    32'(alu_cnt), 2);
    check("n_errs",   32'(err_cnt), 5);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_cmd_ctrl.md
RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of received bytes and register-file data.
REQ-002 Parameter ADDR_WIDTH, default 4: register-file address width.
REQ-003 Parameter TIMEOUT_CYC, default 4096: max CLK cycles allowed between bytes of one frame.
REQ-004 CLK  in  1: single clock; all logic on rising edge.
REQ-005 RST  in  1: reset, synchronous, active-high.
REQ-006 RX_P_DATA  in  DATA_WIDTH: byte from UART receiver (synchronised into CLK domain).
REQ-007 RX_D_VLD  in  1: one-cycle pulse, RX_P_DATA valid.
REQ-008 RF_WrEn  out  1: register-file write strobe, one cycle.
REQ-009 RF_RdEn  out  1: register-file read strobe, one cycle.
REQ-010 RF_Address  out  ADDR_WIDTH: register-file address, valid with either strobe.
REQ-011 RF_WrData  out  DATA_WIDTH: write data, valid with RF_WrEn.
REQ-012 ALU_EN  out  1: ALU execute strobe, one cycle.
REQ-013 ALU_FUN  out  4: ALU function code, valid with ALU_EN.
REQ-014 FRAME_ERR  out  1: one-cycle pulse on unknown command byte or inter-byte timeout.

Function
REQ-015 Commands SHALL be: 0xAA write (addr, data); 0xBB read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU no operands (fun).
REQ-016 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN; bytes consumed only on RX_D_VLD=1.
REQ-017 IDLE: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->ALU_FUN; any other byte -> stay IDLE, FRAME_ERR pulse.
REQ-018 WR_ADDR: latch RX_P_DATA[ADDR_WIDTH-1:0] (upper bits ignored) -> WR_DATA.
REQ-019 WR_DATA: RF_WrEn=1, RF_Address=latched addr, RF_WrData=byte, next cycle -> IDLE.
REQ-020 RD_ADDR: RF_RdEn=1, RF_Address=byte[ADDR_WIDTH-1:0] -> IDLE.
REQ-021 OP_A: RF write of byte to address 0 -> OP_B; OP_B: RF write of byte to address 1 -> ALU_FUN.
REQ-022 ALU_FUN: ALU_EN=1, ALU_FUN=byte[3:0] -> IDLE.
REQ-023 All outputs registered; strobes assert exactly the cycle after the accepting RX_D_VLD cycle, for one cycle.
REQ-024 RF_Address/RF_WrData/ALU_FUN SHALL hold last value when strobes are low.
REQ-025 Timeout counter clears on every accepted byte and in IDLE; counting in any non-IDLE state; reaching TIMEOUT_CYC-1 -> IDLE plus FRAME_ERR pulse.
REQ-026 Timeout and RX_D_VLD in the same cycle: byte wins, no error.
REQ-027 Back-to-back RX_D_VLD on consecutive cycles SHALL each be consumed; a new 0xAA etc. right after a completing byte is accepted without gap.
REQ-028 Command bytes received in non-IDLE states are treated as payload, not commands.

Reset
REQ-029 RST=1 at any clock edge: state IDLE, timeout counter 0, all strobes and FRAME_ERR 0, RF_Address/RF_WrData/ALU_FUN 0.
REQ-030 RST mid-frame SHALL abandon the frame with no strobe emitted for it.

Structure
REQ-031 Command opcodes (0xAA/0xBB/0xCC/0xDD), operand addresses 0/1 and state encoding SHALL live in shared package sys_ctrl_pkg.
REQ-032 Timeout counter SHALL be sub-module frame_timeout (clear, enable, expire pulse); FSM stays in rx_cmd_ctrl.

Verification
REQ-033 Bytes 0xAA,0x05,0x3C -> one-cycle RF_WrEn, RF_Address=5, RF_WrData=0x3C, cycle after third valid.
REQ-034 Bytes 0xBB,0x17 -> RF_RdEn one cycle, RF_Address=7; RF_WrEn never asserted.
REQ-035 Bytes 0xCC,0x10,0x20,0x02 -> RF writes addr0=0x10, addr1=0x20, then ALU_EN with ALU_FUN=2.
REQ-036 Byte 0x55 in IDLE -> FRAME_ERR pulse, no strobes; following 0xDD,0x01 -> ALU_EN, ALU_FUN=1.
REQ-037 0xAA,0x03 then silence TIMEOUT_CYC cycles -> FRAME_ERR, IDLE; late 0x99 -> FRAME_ERR (unknown cmd), no write.
REQ-038 RST asserted between 0xCC and operand B -> no ALU_EN; all outputs 0 next cycle.
